// File: rtl/vga_line_streamer.sv
// Pixel FIFO between a renderer and a VGA line sink: each line request drains
// exactly LINE_LEN pixels on consecutive cycles, padding with FILL_COLOR on underrun.
module vga_line_streamer #(
  parameter int                PIX_W      = 6,
  parameter int                DEPTH      = 16,
  parameter int                LINE_LEN   = 160,
  parameter logic [PIX_W-1:0]  FILL_COLOR = {PIX_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_valid_in,
  input  logic [PIX_W-1:0]           pix_data_in,
  output logic                       pix_ready_out,
  input  logic                       vga_ready_in,
  output logic                       vga_data_valid_out,
  output logic [PIX_W-1:0]           vga_data_out,
  output logic                       line_active_out,
  output logic [$clog2(DEPTH):0]     fill_level_out,
  output logic [15:0]                underrun_cnt_out
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);
  localparam int              CW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(LINE_LEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CW-1:0]       cnt_r;
  logic [CW-1:0]       cnt_nxt_s;
  logic                emit_s;
  logic                push_s;
  logic                pop_s;
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         fill_r;
  logic [PIX_W-1:0]    mem_r [DEPTH];
  logic                vga_valid_r;
  logic [PIX_W-1:0]    vga_data_r;
  logic                line_active_r;
  logic [15:0]         underrun_r;

  // Pops only look at the registered fill, so a pixel pushed into an empty FIFO
  // can never leave in the same cycle.
  assign pix_ready_out = ~rst & (fill_r < FULL_LVL);
  assign push_s        = pix_valid_in & pix_ready_out;
  assign pop_s         = emit_s & (fill_r != {(AW+1){1'b0}});

  // FSM state and pixel-in-line counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next state: the request edge itself emits pixel 0; the edge emitting the
  // last pixel returns to IDLE so a new request can follow with no gap.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    emit_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (vga_ready_in) begin
          emit_s = 1'b1;
          if (LAST_CNT == {CW{1'b0}}) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CW{1'b0}};
          end else begin
            state_nxt_s = ST_BURST;
            cnt_nxt_s   = CW'(1);
          end
        end else begin
          cnt_nxt_s = {CW{1'b0}};
        end
      end
      ST_BURST: begin
        emit_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      fill_r   <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fill_r <= fill_r + (AW+1)'(1);
        2'b01:   fill_r <= fill_r - (AW+1)'(1);
        default: fill_r <= fill_r;
      endcase
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= pix_data_in;
    end
  end

  // Registered VGA outputs and saturating underrun counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_valid_r   <= 1'b0;
      vga_data_r    <= {PIX_W{1'b0}};
      line_active_r <= 1'b0;
      underrun_r    <= 16'h0000;
    end else begin
      vga_valid_r   <= emit_s;
      line_active_r <= emit_s;
      if (pop_s) begin
        vga_data_r <= mem_r[rd_ptr_r];
      end else if (emit_s) begin
        vga_data_r <= FILL_COLOR;
      end else begin
        vga_data_r <= {PIX_W{1'b0}};
      end
      if (emit_s && !pop_s && (underrun_r != 16'hFFFF)) begin
        underrun_r <= underrun_r + 16'h0001;
      end
    end
  end

  assign vga_data_valid_out = vga_valid_r;
  assign vga_data_out       = vga_data_r;
  assign line_active_out    = line_active_r;
  assign fill_level_out     = fill_r;
  assign underrun_cnt_out   = underrun_r;

endmodule

// File: tb/tb_vga_line_streamer.sv
// Directed bench for vga_line_streamer (PIX_W=6, DEPTH=16, LINE_LEN=8, FILL_COLOR=3F):
// a vector table for full-line and underrun lines, plus hand sequences for the rest.
module tb_vga_line_streamer;

  localparam int PIX_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pix_valid_in = 1'b0;
  logic [PIX_W-1:0]  pix_data_in = 6'h00;
  logic              pix_ready_out;
  logic              vga_ready_in = 1'b0;
  logic              vga_data_valid_out;
  logic [PIX_W-1:0]  vga_data_out;
  logic              line_active_out;
  logic [4:0]        fill_level_out;
  logic [15:0]       underrun_cnt_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        pv;
    logic [5:0]  pd;
    logic        req;
    logic        ev;
    logic [5:0]  ed;
    logic [4:0]  ef;
  } vec_t;

  vec_t tbl[$];

  vga_line_streamer #(
    .PIX_W(6), .DEPTH(16), .LINE_LEN(8), .FILL_COLOR(6'h3F)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_valid_in(pix_valid_in), .pix_data_in(pix_data_in), .pix_ready_out(pix_ready_out),
    .vga_ready_in(vga_ready_in), .vga_data_valid_out(vga_data_valid_out),
    .vga_data_out(vga_data_out), .line_active_out(line_active_out),
    .fill_level_out(fill_level_out), .underrun_cnt_out(underrun_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [5:0] ed,
                         input logic [4:0] ef, input logic er);
    chk({tag, ".valid"},  32'(vga_data_valid_out), 32'(ev));
    chk({tag, ".data"},   32'(vga_data_out),       32'(ed));
    chk({tag, ".fill"},   32'(fill_level_out),     32'(ef));
    chk({tag, ".active"}, 32'(line_active_out),    32'(ev));
    chk({tag, ".ready"},  32'(pix_ready_out),      32'(er));
  endtask

  function automatic void add(input logic pv, input logic [5:0] pd, input logic req,
                              input logic ev, input logic [5:0] ed, input logic [4:0] ef);
    vec_t v;
    v.pv = pv; v.pd = pd; v.req = req; v.ev = ev; v.ed = ed; v.ef = ef;
    tbl.push_back(v);
  endfunction

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    pix_valid_in = 1'b0;
    vga_ready_in = 1'b0;
    #1;
    chk_out(tag, 1'b0, 6'h00, 5'd0, 1'b0);
    chk({tag, ".underrun"}, 32'(underrun_cnt_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_seq(input int n, input logic [5:0] base);
    for (int i = 0; i < n; i++) begin
      pix_valid_in = 1'b1;
      pix_data_in  = base + 6'(i);
      tick();
    end
    pix_valid_in = 1'b0;
    pix_data_in  = 6'h15;
  endtask

  initial begin
    // Full line: 8 pixels then a one-cycle request
    for (int i = 0; i < 8; i++) add(1'b1, 6'(i + 1), 1'b0, 1'b0, 6'h00, 5'(i + 1));
    add(1'b0, 6'h2A, 1'b1, 1'b1, 6'h01, 5'd7);
    for (int k = 2; k <= 8; k++) add(1'b0, 6'h2A, 1'b0, 1'b1, 6'(k), 5'(8 - k));
    add(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 5'd0);
    // Underrun: 3 pixels, then 5 fill pixels
    add(1'b1, 6'h0A, 1'b0, 1'b0, 6'h00, 5'd1);
    add(1'b1, 6'h0B, 1'b0, 1'b0, 6'h00, 5'd2);
    add(1'b1, 6'h0C, 1'b0, 1'b0, 6'h00, 5'd3);
    add(1'b0, 6'h2A, 1'b1, 1'b1, 6'h0A, 5'd2);
    add(1'b0, 6'h2A, 1'b0, 1'b1, 6'h0B, 5'd1);
    add(1'b0, 6'h2A, 1'b0, 1'b1, 6'h0C, 5'd0);
    for (int k = 0; k < 5; k++) add(1'b0, 6'h2A, 1'b0, 1'b1, 6'h3F, 5'd0);
    add(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 5'd0);

    do_reset("reset0");
    for (int i = 0; i < tbl.size(); i++) begin
      pix_valid_in = tbl[i].pv;
      pix_data_in  = tbl[i].pd;
      vga_ready_in = tbl[i].req;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ef, 1'b1);
      if (i == 16) chk("full_line.underrun", 32'(underrun_cnt_out), 32'd0);
    end
    vga_ready_in = 1'b0;
    chk("underrun.count", 32'(underrun_cnt_out), 32'd5);

    // Backpressure: 17th pixel waits until the first pop
    do_reset("reset1");
    pix_valid_in = 1'b1;
    for (int c = 0; c < 16; c++) begin
      pix_data_in = 6'(c + 1);
      tick();
    end
    pix_data_in = 6'd17;
    chk_out("bp.full", 1'b0, 6'h00, 5'd16, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    chk_out("bp.hold", 1'b0, 6'h00, 5'd16, 1'b0);
    vga_ready_in = 1'b1;
    tick();
    vga_ready_in = 1'b0;
    chk_out("bp.pop1", 1'b1, 6'd1, 5'd15, 1'b1);
    tick();
    pix_valid_in = 1'b0;
    chk_out("bp.pop2", 1'b1, 6'd2, 5'd15, 1'b1);
    for (int p = 3; p <= 8; p++) begin
      tick();
      chk_out($sformatf("bp.pop%0d", p), 1'b1, 6'(p), 5'(17 - p), 1'b1);
    end
    tick();
    chk_out("bp.end", 1'b0, 6'h00, 5'd9, 1'b1);

    // Back-to-back lines with ignored mid-burst requests
    do_reset("reset2");
    push_seq(16, 6'h01);
    for (int p = 1; p <= 16; p++) begin
      vga_ready_in = (p == 1) || (p == 5) || (p == 9) || (p == 12);
      tick();
      chk_out($sformatf("b2b.p%0d", p), 1'b1, 6'(p), 5'(16 - p), 1'b1);
    end
    vga_ready_in = 1'b0;
    tick();
    chk_out("b2b.idle", 1'b0, 6'h00, 5'd0, 1'b1);
    chk("b2b.underrun", 32'(underrun_cnt_out), 32'd0);

    // Concurrent push/pop at fill 4
    do_reset("reset3");
    push_seq(4, 6'h20);
    for (int k = 0; k < 8; k++) begin
      vga_ready_in = (k == 0);
      pix_valid_in = 1'b1;
      pix_data_in  = 6'h24 + 6'(k);
      tick();
      chk_out($sformatf("cc.p%0d", k), 1'b1, 6'h20 + 6'(k), 5'd4, 1'b1);
    end
    pix_valid_in = 1'b0;
    vga_ready_in = 1'b0;
    tick();
    chk_out("cc.idle", 1'b0, 6'h00, 5'd4, 1'b1);

    // Reset mid-burst, then a line made only of fill pixels
    do_reset("reset4");
    push_seq(8, 6'h01);
    vga_ready_in = 1'b1;
    tick();
    vga_ready_in = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk_out("mid.p4", 1'b1, 6'h04, 5'd4, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("mid.rst", 1'b0, 6'h00, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vga_ready_in = 1'b1;
    tick();
    vga_ready_in = 1'b0;
    chk_out("mid.f1", 1'b1, 6'h3F, 5'd0, 1'b1);
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk_out($sformatf("mid.f%0d", c), 1'b1, 6'h3F, 5'd0, 1'b1);
    end
    tick();
    chk_out("mid.idle", 1'b0, 6'h00, 5'd0, 1'b1);
    chk("mid.underrun", 32'(underrun_cnt_out), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
